reg_operand_fetch: RTL and testbench
====================================

REG_OPERAND_FETCH -- requirements
Module: reg_operand_fetch

Interface
REQ-001 SHALL take parameters WIDTH (default `WIDTH = 32, operand data width), REG_ADDR_LEN (default `REG_ADDR_LEN = 5, register index width) and NUM_REGS (default `NUM_REGS = 32, scoreboard depth).
REQ-002 SHALL have ports, in order:
  clk  in  1  single clock, all state updates on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  in_valid  in  1  decoded instruction request valid
  in_ready  out  1  block can accept a request
  in_ra, in_rb  in  REG_ADDR_LEN  source register indices
  in_use_a, in_use_b  in  1  source A/B is actually read
  in_rd  in  REG_ADDR_LEN  destination register index
  in_wr  in  1  instruction will write in_rd
  out_valid  out  1  operands available
  out_ready  in  1  consumer takes operands
  out_a, out_b  out  WIDTH  fetched operand values
  out_rd  out  REG_ADDR_LEN  destination passed through
  out_wr  out  1  in_wr passed through
  ra, rb  out  REG_ADDR_LEN  register file read addresses
  r_en_A, r_en_B  out  1  register file read enables
  dataA, dataB  in  WIDTH  register file read data
  st_A, st_B  in  1  register file read strobes
  wb_valid  in  1  writeback retired this cycle
  wb_rd  in  REG_ADDR_LEN  register retired by writeback

Function
REQ-003 SHALL implement FSM states IDLE, CHECK, READ, HOLD; in_ready = (state == IDLE).
REQ-004 IDLE: on in_valid & in_ready SHALL latch in_ra, in_rb, in_use_a, in_use_b, in_rd, in_wr and go to CHECK.
REQ-005 SHALL keep a NUM_REGS-bit busy scoreboard; busy[0] is always 0.
REQ-006 CHECK: hazard = (in_use_a & busy[ra]) | (in_use_b & busy[rb]) | (in_wr & busy[rd]), evaluated on latched values; hazard -> stay in CHECK, else -> READ.
REQ-007 READ: r_en_A = latched use_a, r_en_B = latched use_b, both 0 in every other state; ra/rb driven from latched indices in all states.
REQ-008 READ: at the rising edge ending the cycle, if every enabled port's strobe is 1, SHALL capture dataA into out_a (0 if use_a = 0) and dataB into out_b (0 if use_b = 0), then go to HOLD; otherwise stay in READ.
REQ-009 On the READ->HOLD transition, if wr = 1 and rd != 0, busy[rd] SHALL be set.
REQ-010 HOLD: out_valid = 1, out_a/out_b/out_rd/out_wr stable; on out_ready go to IDLE; out_valid = 0 in every other state.
REQ-011 wb_valid with wb_rd != 0 SHALL clear busy[wb_rd]; a clear for the same index in the cycle of a set (REQ-009) loses: bit ends 1.
REQ-012 Clear and hazard check in the same cycle: CHECK sees pre-clear busy; no bypass, stall lasts one extra cycle.
REQ-013 Zero-hazard latency: accept edge -> out_valid high 3 cycles later (CHECK, READ, HOLD); throughput 1 request per 4 cycles with out_ready held high.
REQ-014 wb_valid SHALL be honoured in every state, including while stalled in CHECK.

Reset
REQ-015 rst_n low SHALL asynchronously force state IDLE, busy all 0, out_a/out_b 0, out_rd 0, out_wr 0, latched fields 0; so in_ready = 1, out_valid = 0, r_en_A = r_en_B = 0.
REQ-016 Reset mid-operation SHALL drop the in-flight request with no pending busy bit remaining.

Structure
REQ-017 WIDTH, REG_ADDR_LEN, NUM_REGS defaults SHALL come from the shared params.v defines; state encodings SHALL be localparams in this module.
REQ-018 Scoreboard SHALL be a sub-module reg_scoreboard (set port, clear port, two query ports plus rd query, set-wins rule).

Verification
REQ-019 No hazard: req ra=3, rb=4, use both, rd=5, wr=1, regfile r3=0x11, r4=0x22 -> out_valid 3 cycles after accept, out_a=0x11, out_b=0x22, busy[5]=1.
REQ-020 RAW stall: rd=5 pending, next req ra=5 -> holds in CHECK; wb_valid wb_rd=5 at cycle N -> READ at N+2, out_a = new r5.
REQ-021 Register 0: rd=0, wr=1 -> busy unchanged; then ra=0, use_a=1 -> no stall, out_a=0.
REQ-022 Set/clear collision: busy[7]=1, wb_valid wb_rd=7 in cycle of READ->HOLD for a wr rd=7 request -> busy[7]=1 afterwards.
REQ-023 Back-pressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-024 Async reset in READ with busy[9]=1 -> immediate IDLE, r_en_A/r_en_B=0, busy all 0, out_valid=0.

Source files
------------

// File: rtl/reg_operand_fetch_pkg.sv
// Shared definitions for the register operand fetch stage.
// Holds the default widths used by the stage, its interface and the scoreboard,
// plus the read-strobe completion helper.
package reg_operand_fetch_pkg;

    localparam int unsigned DefWidth      = 32;
    localparam int unsigned DefRegAddrLen = 5;
    localparam int unsigned DefNumRegs    = 32;

    // A read completes once every enabled port has strobed; disabled ports never block.
    function automatic logic strobes_ok(input logic use_a, input logic use_b,
                                        input logic st_a, input logic st_b);
        return (!use_a || st_a) && (!use_b || st_b);
    endfunction

endpackage

// File: rtl/reg_operand_fetch_if.sv
// Bundle of the operand fetch stage's bus signals.
//   request  : in_valid/in_ready, in_ra/in_rb/in_use_a/in_use_b, in_rd/in_wr
//   response : out_valid/out_ready, out_a/out_b, out_rd/out_wr
//   regfile  : ra/rb/r_en_A/r_en_B out, dataA/dataB/st_A/st_B in
//   writeback: wb_valid/wb_rd
// slave is the fetch stage's view; master is the surrounding pipeline's view.
interface reg_operand_fetch_if #(
    parameter int unsigned WIDTH        = reg_operand_fetch_pkg::DefWidth,
    parameter int unsigned REG_ADDR_LEN = reg_operand_fetch_pkg::DefRegAddrLen
);
    logic                    in_valid;
    logic                    in_ready;
    logic [REG_ADDR_LEN-1:0] in_ra;
    logic [REG_ADDR_LEN-1:0] in_rb;
    logic                    in_use_a;
    logic                    in_use_b;
    logic [REG_ADDR_LEN-1:0] in_rd;
    logic                    in_wr;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_a;
    logic [WIDTH-1:0]        out_b;
    logic [REG_ADDR_LEN-1:0] out_rd;
    logic                    out_wr;
    logic [REG_ADDR_LEN-1:0] ra;
    logic [REG_ADDR_LEN-1:0] rb;
    logic                    r_en_A;
    logic                    r_en_B;
    logic [WIDTH-1:0]        dataA;
    logic [WIDTH-1:0]        dataB;
    logic                    st_A;
    logic                    st_B;
    logic                    wb_valid;
    logic [REG_ADDR_LEN-1:0] wb_rd;

    modport slave (
        input  in_valid, in_ra, in_rb, in_use_a, in_use_b, in_rd, in_wr,
        output in_ready,
        input  out_ready,
        output out_valid, out_a, out_b, out_rd, out_wr,
        output ra, rb, r_en_A, r_en_B,
        input  dataA, dataB, st_A, st_B,
        input  wb_valid, wb_rd
    );

    modport master (
        output in_valid, in_ra, in_rb, in_use_a, in_use_b, in_rd, in_wr,
        input  in_ready,
        output out_ready,
        input  out_valid, out_a, out_b, out_rd, out_wr,
        input  ra, rb, r_en_A, r_en_B,
        output dataA, dataB, st_A, st_B,
        output wb_valid, wb_rd
    );

endinterface

// File: rtl/reg_operand_fetch_scoreboard.sv
// Busy-register scoreboard for the operand fetch stage.
//   set_i/set_idx_i : mark a register as having a write in flight
//   clr_i/clr_idx_i : writeback retired that register
//   q*_idx_i        : three query ports (source A, source B, destination)
// A set and a clear of the same index in one cycle leave the bit set.
// Register 0 is never busy.
module reg_scoreboard #(
    parameter int unsigned REG_ADDR_LEN = reg_operand_fetch_pkg::DefRegAddrLen,
    parameter int unsigned NUM_REGS     = reg_operand_fetch_pkg::DefNumRegs
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_i,
    input  logic [REG_ADDR_LEN-1:0] set_idx_i,
    input  logic                    clr_i,
    input  logic [REG_ADDR_LEN-1:0] clr_idx_i,
    input  logic [REG_ADDR_LEN-1:0] qa_idx_i,
    input  logic [REG_ADDR_LEN-1:0] qb_idx_i,
    input  logic [REG_ADDR_LEN-1:0] qd_idx_i,
    output logic                    busy_a_o,
    output logic                    busy_b_o,
    output logic                    busy_d_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_idx_i] = 1'b0;
        // Applied after the clear so a same-cycle set wins.
        if (set_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_a_o = busy_q[qa_idx_i];
    assign busy_b_o = busy_q[qb_idx_i];
    assign busy_d_o = busy_q[qd_idx_i];

endmodule

// File: rtl/reg_operand_fetch.sv
// Register operand fetch stage.
// Accepts one decoded instruction, waits until none of the registers it reads
// or writes has a write in flight, reads the register file and presents the
// operands until the consumer takes them.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : request, response, register file and writeback signals
module reg_operand_fetch import reg_operand_fetch_pkg::*; #(
    parameter int unsigned WIDTH        = DefWidth,
    parameter int unsigned REG_ADDR_LEN = DefRegAddrLen,
    parameter int unsigned NUM_REGS     = DefNumRegs
) (
    input logic                clk,
    input logic                rst_n,
    reg_operand_fetch_if.slave bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCheck = 2'd1;
    localparam logic [1:0] StRead  = 2'd2;
    localparam logic [1:0] StHold  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [REG_ADDR_LEN-1:0] ra_q, rb_q, rd_q;
    logic                    use_a_q, use_b_q, wr_q;
    logic [WIDTH-1:0]        out_a_q, out_b_q;

    logic accept, fetch_done, hazard;
    logic busy_a, busy_b, busy_d;

    assign accept     = (state_q == StIdle) && bus.in_valid;
    assign fetch_done = (state_q == StRead) && strobes_ok(use_a_q, use_b_q, bus.st_A, bus.st_B);
    // Uses registered busy bits, so a same-cycle writeback only helps next cycle.
    assign hazard     = (use_a_q && busy_a) || (use_b_q && busy_b) || (wr_q && busy_d);

    reg_scoreboard #(
        .REG_ADDR_LEN (REG_ADDR_LEN),
        .NUM_REGS     (NUM_REGS)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_i     (fetch_done && wr_q && (rd_q != '0)),
        .set_idx_i (rd_q),
        .clr_i     (bus.wb_valid && (bus.wb_rd != '0)),
        .clr_idx_i (bus.wb_rd),
        .qa_idx_i  (ra_q),
        .qb_idx_i  (rb_q),
        .qd_idx_i  (rd_q),
        .busy_a_o  (busy_a),
        .busy_b_o  (busy_b),
        .busy_d_o  (busy_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.in_valid)  state_d = StCheck;
            StCheck: if (!hazard)       state_d = StRead;
            StRead:  if (fetch_done)    state_d = StHold;
            StHold:  if (bus.out_ready) state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            use_a_q <= 1'b0;
            use_b_q <= 1'b0;
            wr_q    <= 1'b0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ra_q    <= bus.in_ra;
                rb_q    <= bus.in_rb;
                rd_q    <= bus.in_rd;
                use_a_q <= bus.in_use_a;
                use_b_q <= bus.in_use_b;
                wr_q    <= bus.in_wr;
            end
            if (fetch_done) begin
                out_a_q <= use_a_q ? bus.dataA : '0;
                out_b_q <= use_b_q ? bus.dataB : '0;
            end
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_wr    = wr_q;
    assign bus.ra        = ra_q;
    assign bus.rb        = rb_q;
    assign bus.r_en_A    = (state_q == StRead) && use_a_q;
    assign bus.r_en_B    = (state_q == StRead) && use_b_q;

endmodule

// File: tb/tb_reg_operand_fetch.sv
module tb_reg_operand_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_operand_fetch_if #(.WIDTH(32), .REG_ADDR_LEN(5)) bus ();

    reg_operand_fetch #(.WIDTH(32), .REG_ADDR_LEN(5), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file model: fixed contents, strobes only enabled ports after st_delay cycles.
    logic [31:0] rf [32];
    int          st_delay = 0;
    int          rd_cnt = 0;
    logic [31:0] mbusy = '0;   // reference busy set
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge clk) rd_cnt <= (bus.r_en_A || bus.r_en_B) ? rd_cnt + 1 : 0;

    assign bus.dataA = rf[bus.ra];
    assign bus.dataB = rf[bus.rb];
    assign bus.st_A  = bus.r_en_A && (rd_cnt >= st_delay);
    assign bus.st_B  = bus.r_en_B && (rd_cnt >= st_delay);

    typedef struct {
        logic [4:0]  ra, rb, rd;
        logic        ua, ub, wr;
        int          d, h, cyc;
        logic [31:0] ea, eb;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [4:0] ra, rb, rd, input logic ua, ub, wr);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", bus.in_ready, 1);
        bus.in_ra = ra; bus.in_rb = rb; bus.in_rd = rd;
        bus.in_use_a = ua; bus.in_use_b = ub; bus.in_wr = wr;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        // Scramble request fields: the stage must work from its latched copy.
        bus.in_ra = 5'($urandom); bus.in_rb = 5'($urandom); bus.in_rd = 5'($urandom);
        bus.in_use_a = 1'($urandom); bus.in_use_b = 1'($urandom); bus.in_wr = 1'($urandom);
    endtask

    task automatic wb_pulse(input logic [4:0] r);
        bus.wb_valid = 1'b1;
        bus.wb_rd = r;
        tick();
        bus.wb_valid = 1'b0;
        mbusy[r] = 1'b0;
        mbusy[0] = 1'b0;
    endtask

    // Full transaction. While stalled the bench retires one blocking register
    // per cycle. exp_cyc < 0 derives the cycle count from the reference model.
    task automatic txn(input logic [4:0] ra, rb, rd, input logic ua, ub, wr,
                       input int d, h, exp_cyc, input logic [31:0] ea, eb, input string nm);
        logic [4:0] clr [$];
        logic [4:0] r;
        int lat;
        int exp;
        if (ua && mbusy[ra]) clr.push_back(ra);
        if (ub && mbusy[rb] && !(ua && ra == rb)) clr.push_back(rb);
        if (wr && mbusy[rd] && !(ua && rd == ra) && !(ub && rd == rb)) clr.push_back(rd);
        exp = (exp_cyc >= 0) ? exp_cyc : 3 + clr.size() + ((ua || ub) ? d : 0);
        st_delay = d;
        accept(ra, rb, rd, ua, ub, wr);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            if (clr.size() > 0) begin
                r = clr.pop_front();
                bus.wb_valid = 1'b1;
                bus.wb_rd = r;
                mbusy[r] = 1'b0;
            end else begin
                bus.wb_valid = 1'b0;
            end
            tick();
            lat++;
        end
        bus.wb_valid = 1'b0;
        chk({nm, "_cycles"}, lat + 1, exp);
        chk({nm, "_a"}, bus.out_a, ea);
        chk({nm, "_b"}, bus.out_b, eb);
        chk({nm, "_rd_wr"}, {bus.out_rd, bus.out_wr}, {rd, wr});
        chk({nm, "_hold_ctl"}, {bus.in_ready, bus.r_en_A, bus.r_en_B}, 3'b000);
        for (int i = 0; i < h; i++) begin
            tick();
            chk({nm, "_bp_stable"}, {bus.out_valid, bus.in_ready, bus.out_a, bus.out_b},
                {2'b10, ea, eb});
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({nm, "_to_idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
        if (wr && rd != 0) mbusy[rd] = 1'b1;
        chk({nm, "_busy"}, dut.u_sb.busy_q, mbusy);
    endtask

    initial begin
        logic [4:0] ra, rb, rd;
        logic       ua, ub, wr;
        int         d, h;

        for (int i = 0; i < 32; i++) rf[i] = 32'h1111_1111 * i;
        rf[3] = 32'h11;
        rf[4] = 32'h22;

        vt[0] = '{5'd3, 5'd4,  5'd5, 1'b1, 1'b1, 1'b1, 0, 0, 3, 32'h11,        32'h22};
        vt[1] = '{5'd5, 5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 0, 0, 4, 32'h5555_5555, 32'h0};
        vt[2] = '{5'd0, 5'd2,  5'd0, 1'b1, 1'b1, 1'b1, 1, 2, 4, 32'h0,         32'h2222_2222};
        vt[3] = '{5'd6, 5'd6,  5'd6, 1'b0, 1'b1, 1'b1, 2, 0, 5, 32'h0,         32'h6666_6666};
        vt[4] = '{5'd6, 5'd7,  5'd8, 1'b1, 1'b1, 1'b0, 0, 5, 4, 32'h6666_6666, 32'h7777_7777};
        vt[5] = '{5'd9, 5'd10, 5'd9, 1'b0, 1'b0, 1'b1, 3, 1, 3, 32'h0,         32'h0};
        vt[6] = '{5'd1, 5'd9,  5'd2, 1'b1, 1'b0, 1'b1, 0, 0, 3, 32'h1111_1111, 32'h0};
        vt[7] = '{5'd1, 5'd1,  5'd2, 1'b1, 1'b1, 1'b1, 0, 0, 4, 32'h1111_1111, 32'h1111_1111};
        vt[8] = '{5'd9, 5'd2,  5'd0, 1'b1, 1'b1, 1'b0, 0, 0, 5, 32'h9999_9999, 32'h2222_2222};

        bus.in_valid = 0; bus.in_ra = 0; bus.in_rb = 0; bus.in_rd = 0;
        bus.in_use_a = 0; bus.in_use_b = 0; bus.in_wr = 0;
        bus.out_ready = 0; bus.wb_valid = 0; bus.wb_rd = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", {bus.in_ready, bus.out_valid, bus.r_en_A, bus.r_en_B}, 4'b1000);
        chk("rst_out", {bus.out_a, bus.out_b, bus.out_rd, bus.out_wr}, '0);
        chk("rst_busy", dut.u_sb.busy_q, 32'h0);
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 9; i++)
            txn(vt[i].ra, vt[i].rb, vt[i].rd, vt[i].ua, vt[i].ub, vt[i].wr,
                vt[i].d, vt[i].h, vt[i].cyc, vt[i].ea, vt[i].eb, $sformatf("vec%0d", i));

        // RAW stall released by a writeback in cycle N: READ in N+2
        txn(5'd1, 5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 0, 0, 3, 32'h0, 32'h0, "r20_set");
        rf[5] = 32'hCAFE_0005;
        st_delay = 0;
        accept(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("r20_stall", {bus.out_valid, bus.r_en_A, bus.in_ready}, 3'b000);
            tick();
        end
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'd5;
        chk("r20_stall_n", bus.r_en_A, 0);
        tick();
        bus.wb_valid = 1'b0;
        mbusy[5] = 1'b0;
        chk("r20_n1_check", bus.r_en_A, 0);
        tick();
        chk("r20_n2_read", bus.r_en_A, 1);
        tick();
        chk("r20_valid", bus.out_valid, 1);
        chk("r20_a", bus.out_a, 32'hCAFE_0005);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Same-cycle set and clear of register 7: set wins
        st_delay = 0;
        accept(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1);
        tick();
        chk("r22_read", {bus.r_en_A, bus.r_en_B}, 2'b11);
        bus.wb_valid = 1'b1;
        bus.wb_rd = 5'd7;
        tick();
        bus.wb_valid = 1'b0;
        chk("r22_valid", bus.out_valid, 1);
        chk("r22_busy7", dut.u_sb.busy_q[7], 1);
        mbusy[7] = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("r22_busy", dut.u_sb.busy_q, mbusy);

        // Randomised transactions against the reference model
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) wb_pulse(5'($urandom_range(0, 31)));
            ra = 5'($urandom); rb = 5'($urandom); rd = 5'($urandom);
            ua = 1'($urandom); ub = 1'($urandom); wr = 1'($urandom);
            d = $urandom_range(0, 2);
            h = $urandom_range(0, 2);
            txn(ra, rb, rd, ua, ub, wr, d, h, -1, ua ? rf[ra] : 32'h0, ub ? rf[rb] : 32'h0, "rnd");
        end

        // Asynchronous reset while stalled in READ with register 9 busy
        for (int i = 1; i < 32; i++) if (mbusy[i]) wb_pulse(5'(i));
        txn(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 0, 0, 3, 32'h0, 32'h0, "r24_set");
        st_delay = 5;
        accept(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        chk("r24_in_read", bus.r_en_A, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r24_ctl", {bus.in_ready, bus.out_valid, bus.r_en_A, bus.r_en_B}, 4'b1000);
        chk("r24_busy", dut.u_sb.busy_q, 32'h0);
        chk("r24_out", {bus.out_a, bus.out_rd, bus.out_wr}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mbusy = '0;
        st_delay = 0;
        tick();
        txn(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 0, 0, 3, 32'h9999_9999, 32'h0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
